// File: rtl/sram_port_arbiter.sv
// Two-port arbiter sharing one SRAM controller between a cache-refill port and a
// read-only VGA fetch port, with round-robin on contention and a BUSY watchdog.
//
// state  | meaning
// IDLE   | no grant; arbitrate on the request levels sampled at this edge
// BUSY_C | cache owns the SRAM controller, s_req high, waiting for s_done
// BUSY_V | VGA owns the SRAM controller, s_req high, waiting for s_done
// RESP   | one-cycle rdy pulse to the owner (plus err_timeout on abort)
module sram_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_rdy,
  input  logic        v_req,
  input  logic [31:0] v_addr,
  output logic [31:0] v_rdata,
  output logic        v_rdy,
  output logic        s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_done,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_C = 2'd1,
    BUSY_V = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

  state_e      state_q;
  logic        last_grant_v_q;
  logic [7:0]  cnt_q;
  logic        s_req_q;
  logic        s_we_q;
  logic [31:0] s_addr_q;
  logic [31:0] s_wdata_q;
  logic [31:0] c_rdata_q;
  logic [31:0] v_rdata_q;
  logic        c_rdy_q;
  logic        v_rdy_q;
  logic        err_q;

  logic        pick_c;
  logic        pick_v;
  logic        busy_c;

  // On contention the VGA port wins only if the cache was granted last.
  always_comb begin
    pick_v = v_req && (!c_req || !last_grant_v_q);
    pick_c = c_req && !pick_v;
  end

  assign busy_c = (state_q == BUSY_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_v_q <= 1'b1;
      cnt_q          <= 8'd0;
      s_req_q        <= 1'b0;
      s_we_q         <= 1'b0;
      s_addr_q       <= 32'd0;
      s_wdata_q      <= 32'd0;
      c_rdata_q      <= 32'd0;
      v_rdata_q      <= 32'd0;
      c_rdy_q        <= 1'b0;
      v_rdy_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      c_rdy_q <= 1'b0;
      v_rdy_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_c) begin
            state_q        <= BUSY_C;
            last_grant_v_q <= 1'b0;
            cnt_q          <= 8'd0;
            s_req_q        <= 1'b1;
            s_we_q         <= c_we;
            s_addr_q       <= c_addr;
            s_wdata_q      <= c_wdata;
          end else if (pick_v) begin
            state_q        <= BUSY_V;
            last_grant_v_q <= 1'b1;
            cnt_q          <= 8'd0;
            s_req_q        <= 1'b1;
            s_we_q         <= 1'b0;
            s_addr_q       <= v_addr;
            s_wdata_q      <= 32'd0;
          end
        end
        BUSY_C, BUSY_V: begin
          // s_done outranks the watchdog when both land on the same cycle.
          if (s_done) begin
            state_q <= RESP;
            s_req_q <= 1'b0;
            if (busy_c) begin
              c_rdy_q <= 1'b1;
              if (!s_we_q) c_rdata_q <= s_rdata;
            end else begin
              v_rdy_q   <= 1'b1;
              v_rdata_q <= s_rdata;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= RESP;
            s_req_q <= 1'b0;
            err_q   <= 1'b1;
            if (busy_c) begin
              c_rdy_q <= 1'b1;
              if (!s_we_q) c_rdata_q <= ABORT_DATA;
            end else begin
              v_rdy_q   <= 1'b1;
              v_rdata_q <= ABORT_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          s_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_req       = s_req_q;
  assign s_we        = s_we_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign c_rdata     = c_rdata_q;
  assign v_rdata     = v_rdata_q;
  assign c_rdy       = c_rdy_q;
  assign v_rdy       = v_rdy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_sram_port_arbiter;

  localparam int TO = 8;

  logic        clk, rst;
  logic        c_req, c_we, c_rdy, v_req, v_rdy;
  logic [31:0] c_addr, c_wdata, c_rdata, v_addr, v_rdata;
  logic        s_req, s_we, s_done, err_timeout;
  logic [31:0] s_addr, s_wdata, s_rdata;

  sram_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_rdy(c_rdy),
    .v_req(v_req), .v_addr(v_addr), .v_rdata(v_rdata), .v_rdy(v_rdy),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_done(s_done), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
  endtask

  // Reference model: one ownership record per grant, BUSY age in cycles.
  int          m_phase;   // 0 idle, 1 busy, 2 responding
  bit          m_own_v, m_last_v;
  int          m_age;
  logic [31:0] e_addr, e_wdata, e_crd, e_vrd;
  bit          e_we, e_crdy, e_vrdy, e_err;
  logic        win_v;

  assign win_v = (c_req && v_req) ? !m_last_v : v_req;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_own_v <= 1'b0; m_last_v <= 1'b1; m_age <= 0;
      e_addr <= '0; e_wdata <= '0; e_we <= 1'b0;
      e_crd <= '0; e_vrd <= '0; e_crdy <= 1'b0; e_vrdy <= 1'b0; e_err <= 1'b0;
    end else begin
      e_crdy <= 1'b0; e_vrdy <= 1'b0; e_err <= 1'b0;
      if (m_phase == 0) begin
        if (c_req || v_req) begin
          m_phase  <= 1;
          m_age    <= 0;
          m_own_v  <= win_v;
          m_last_v <= win_v;
          e_addr   <= win_v ? v_addr : c_addr;
          e_we     <= win_v ? 1'b0 : c_we;
          e_wdata  <= win_v ? 32'h0 : c_wdata;
        end
      end else if (m_phase == 1) begin
        m_age <= m_age + 1;
        if (s_done || (m_age + 1 >= TO)) begin
          m_phase <= 2;
          e_err   <= !s_done;
          if (m_own_v) begin
            e_vrdy <= 1'b1;
            e_vrd  <= s_done ? s_rdata : 32'hFFFF_FFFF;
          end else begin
            e_crdy <= 1'b1;
            if (!e_we) e_crd <= s_done ? s_rdata : 32'hFFFF_FFFF;
          end
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("s_req", {31'd0, s_req}, {31'd0, m_phase == 1});
      if (m_phase == 1) begin
        chk("s_we", {31'd0, s_we}, {31'd0, e_we});
        chk("s_addr", s_addr, e_addr);
        chk("s_wdata", s_wdata, e_wdata);
      end
      chk("c_rdy", {31'd0, c_rdy}, {31'd0, e_crdy});
      chk("v_rdy", {31'd0, v_rdy}, {31'd0, e_vrdy});
      chk("err_timeout", {31'd0, err_timeout}, {31'd0, e_err});
      chk("c_rdata", c_rdata, e_crd);
      chk("v_rdata", v_rdata, e_vrd);
      chk("rdy_exclusive", {31'd0, c_rdy & v_rdy}, 32'd0);
    end
  end

  // Event monitor (observations only; expectations live in the main sequence).
  int cnt_crdy = 0, cnt_vrdy = 0, cnt_err = 0, cnt_err_rdy = 0, cnt_busy = 0;
  bit rdy_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (c_rdy) begin cnt_crdy++; rdy_log.push_back(1'b0); end
      if (v_rdy) begin cnt_vrdy++; rdy_log.push_back(1'b1); end
      if (err_timeout) cnt_err++;
      if (err_timeout && (c_rdy || v_rdy)) cnt_err_rdy++;
      if (s_req) cnt_busy++;
    end
  end

  logic [31:0] obs_addr, obs_wdata;
  logic        obs_we;

  task automatic wait_sreq(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (s_req) begin ok = 1'b1; break; end
    end
    if (!ok) fail_bound(name);
    obs_addr = s_addr; obs_we = s_we; obs_wdata = s_wdata;
  endtask

  task automatic wait_rdy(input string name, input bit any, input bit is_v);
    bit ok = 1'b0;
    for (int k = 0; k < TO + 6; k++) begin
      if (any ? (c_rdy || v_rdy) : (is_v ? v_rdy : c_rdy)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_bound(name);
  endtask

  task automatic pulse_done(input logic [31:0] data);
    s_done = 1'b1; s_rdata = data;
    @(negedge clk);
    s_done = 1'b0; s_rdata = 32'h0;
  endtask

  // delay < 0: the SRAM never answers.
  task automatic do_txn(input bit is_v, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    if (is_v) begin v_req = 1'b1; v_addr = addr; end
    else begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; end
    wait_sreq("grant_wait");
    if (delay >= 0) begin
      repeat (delay) @(negedge clk);
      pulse_done(rdata);
    end
    wait_rdy("rdy_wait", 1'b0, is_v);
    c_req = 1'b0; v_req = 1'b0; c_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int b_c, b_v, b_e, b_er, b_b, b_log;
  bit exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    v_req = 1'b0; v_addr = '0; s_done = 1'b0; s_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_s_req", {31'd0, s_req}, 32'd0);
    chk("reset_s_addr", s_addr, 32'd0);
    chk("reset_c_rdata", c_rdata, 32'd0);
    chk("reset_v_rdata", v_rdata, 32'd0);
    chk("reset_err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single cache read, s_done in the second BUSY cycle
    b_c = cnt_crdy; b_v = cnt_vrdy;
    do_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1);
    chk("rd_s_addr", obs_addr, 32'h0000_0010);
    chk("rd_s_we", {31'd0, obs_we}, 32'd0);
    chk("rd_c_rdata", c_rdata, 32'h1234_5678);
    chk("rd_c_rdy_count", cnt_crdy - b_c, 32'd1);
    chk("rd_v_rdy_count", cnt_vrdy - b_v, 32'd0);

    // cache write leaves c_rdata alone
    b_c = cnt_crdy;
    do_txn(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0);
    chk("wr_s_we", {31'd0, obs_we}, 32'd1);
    chk("wr_s_wdata", obs_wdata, 32'hCAFE_F00D);
    chk("wr_c_rdata", c_rdata, 32'h1234_5678);
    chk("wr_c_rdy_count", cnt_crdy - b_c, 32'd1);

    // VGA read
    do_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_CAFE, 2);
    chk("vrd_v_rdata", v_rdata, 32'h0BAD_CAFE);
    chk("vrd_s_wdata", obs_wdata, 32'h0);

    // VGA timeout: 8 BUSY cycles then abort
    b_e = cnt_err; b_er = cnt_err_rdy; b_b = cnt_busy; b_v = cnt_vrdy;
    do_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h0, -1);
    chk("to_busy_cycles", cnt_busy - b_b, 32'd8);
    chk("to_v_rdata", v_rdata, 32'hFFFF_FFFF);
    chk("to_err_count", cnt_err - b_e, 32'd1);
    chk("to_err_with_rdy", cnt_err_rdy - b_er, 32'd1);
    chk("to_v_rdy_count", cnt_vrdy - b_v, 32'd1);

    // s_done on the very cycle the watchdog fires
    b_e = cnt_err; b_b = cnt_busy;
    do_txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 32'hA5A5_A5A5, TO - 1);
    chk("sim_c_rdata", c_rdata, 32'hA5A5_A5A5);
    chk("sim_err_count", cnt_err - b_e, 32'd0);
    chk("sim_busy_cycles", cnt_busy - b_b, 32'd8);

    // contention straight after reset: C,V,C,V
    do_reset();
    b_c = cnt_crdy; b_v = cnt_vrdy; b_log = rdy_log.size();
    c_req = 1'b1; v_req = 1'b1; c_we = 1'b0; c_addr = 32'h100; v_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      wait_sreq("cont_grant_wait");
      pulse_done(32'h1000 + i);
      wait_rdy("cont_rdy_wait", 1'b1, 1'b0);
      if (i == 3) begin c_req = 1'b0; v_req = 1'b0; end
      @(negedge clk);
    end
    chk("cont_len", rdy_log.size() - b_log, 32'd4);
    for (int i = 0; i < 4; i++)
      if (rdy_log.size() > b_log + i)
        chk("cont_order", {31'd0, rdy_log[b_log + i]}, {31'd0, exp_order[i]});
    chk("cont_c_rdy_count", cnt_crdy - b_c, 32'd2);
    chk("cont_v_rdy_count", cnt_vrdy - b_v, 32'd2);
    chk("cont_v_rdata", v_rdata, 32'h0000_1003);

    // reset in the middle of a cache grant
    c_req = 1'b1; c_addr = 32'h300; c_we = 1'b0;
    wait_sreq("rst_grant_wait");
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_s_req", {31'd0, s_req}, 32'd0);
    chk("rst_mid_c_rdy", {31'd0, c_rdy}, 32'd0);
    c_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    b_c = cnt_crdy;
    pulse_done(32'h7777_7777);
    @(negedge clk);
    chk("rst_stray_c_rdy", cnt_crdy - b_c, 32'd0);
    chk("rst_stray_c_rdata", c_rdata, 32'h0);
    chk("rst_stray_s_req", {31'd0, s_req}, 32'd0);
    c_req = 1'b1; v_req = 1'b1; c_addr = 32'h400; v_addr = 32'h500;
    wait_sreq("post_rst_grant_wait");
    chk("post_rst_grant_addr", obs_addr, 32'h400);
    pulse_done(32'h600D_600D);
    wait_rdy("post_rst_rdy_wait", 1'b1, 1'b0);
    chk("post_rst_c_rdy", {31'd0, c_rdy}, 32'd1);
    c_req = 1'b0; v_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_c_rdata", c_rdata, 32'h600D_600D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d vectors failed", n_err, n_vec);
    $fatal(1);
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles allowed before a grant is aborted (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port c_req, input, 1 bit: cache-refill requester access request, level.
REQ-005 SHALL have port c_we, input, 1 bit: cache access type, 1 = write, 0 = read.
REQ-006 SHALL have port c_addr, input, 32 bits: cache word address.
REQ-007 SHALL have port c_wdata, input, 32 bits: cache write data.
REQ-008 SHALL have port c_rdata, output, 32 bits: cache read data.
REQ-009 SHALL have port c_rdy, output, 1 bit: cache completion pulse.
REQ-010 SHALL have port v_req, input, 1 bit: VGA frame-fetch read request, level; the VGA port is read-only.
REQ-011 SHALL have port v_addr, input, 32 bits: VGA word address.
REQ-012 SHALL have port v_rdata, output, 32 bits: VGA read data.
REQ-013 SHALL have port v_rdy, output, 1 bit: VGA completion pulse.
REQ-014 SHALL have port s_req, output, 1 bit: request to the downstream SRAM controller, level.
REQ-015 SHALL have port s_we, output, 1 bit: downstream access type.
REQ-016 SHALL have port s_addr, output, 32 bits: downstream address.
REQ-017 SHALL have port s_wdata, output, 32 bits: downstream write data.
REQ-018 SHALL have port s_rdata, input, 32 bits: downstream read data, valid when s_done=1.
REQ-019 SHALL have port s_done, input, 1 bit: downstream completion pulse.
REQ-020 SHALL have port err_timeout, output, 1 bit: one-cycle pulse on an aborted access.

Function
REQ-021 SHALL implement the FSM states IDLE, BUSY_C, BUSY_V and RESP.
REQ-022 SHALL, in IDLE, arbitrate on the registered samples of c_req and v_req.
- Only c_req=1: go to BUSY_C.
- Only v_req=1: go to BUSY_V.
- Both =1: grant the requester that was not granted last (round-robin).
- Neither: stay in IDLE.
REQ-023 SHALL hold a last_grant bit that updates on every transition into a BUSY state.
REQ-024 SHALL, on the IDLE->BUSY edge, latch the granted requester's addr, we and wdata into s_addr, s_we and s_wdata, which then stay stable until the grant ends.
- For VGA grants: s_we=0 and s_wdata=0.
REQ-025 SHALL assert s_req=1 throughout BUSY_C and BUSY_V only, registered.
REQ-026 SHALL, on s_done=1 in a BUSY state, go to RESP and, for a read, latch s_rdata into the granted port's rdata register.
- Cache writes leave c_rdata unchanged.
REQ-027 SHALL, in RESP, assert exactly the granted port's rdy for one cycle, then go to IDLE.
REQ-028 SHALL meet this timing: request sampled in IDLE at cycle N; s_req=1 from N+1; s_done at cycle M (M>=N+1); rdy=1 at M+1; IDLE at M+2.
- Minimum round trip is 3 cycles.
REQ-029 SHALL hold each rdata value until the next completed read for that port.
REQ-030 SHALL treat a requester that holds req=1 during RESP as a new request, re-arbitrated in the following IDLE cycle.
- A requester ends a transaction by dropping req on the edge after it sees rdy.
REQ-031 SHALL ignore s_done when it arrives outside a BUSY state.
REQ-032 SHALL count BUSY cycles with an 8-bit counter that clears on BUSY entry.
REQ-033 SHALL abort the grant when the counter reaches TIMEOUT-1 without s_done:
- go to RESP;
- drop s_req;
- for reads, load the granted rdata with 32'hFFFFFFFF;
- pulse rdy and err_timeout together for one cycle.
REQ-034 SHALL give s_done priority if it arrives in the same cycle the timeout is reached (normal completion, no err_timeout).
REQ-035 SHALL never assert c_rdy and v_rdy in the same cycle, and never drive s_req for two grants without passing through IDLE.

Reset
REQ-036 SHALL, while rst=1 (asynchronous, active-high), force:
- FSM to IDLE;
- s_req, s_we, c_rdy, v_rdy and err_timeout to 0;
- s_addr, s_wdata, c_rdata and v_rdata to 0;
- counter to 0;
- last_grant to VGA, so the cache wins the first contention.
REQ-037 SHALL, on reset asserted mid-BUSY, drop s_req immediately, issue no rdy pulse, and discard any s_done arriving after reset is released while in IDLE.

Verification
REQ-038 SHALL cover a single cache read: c_req=1, c_addr=0x00000010, s_done at 2 cycles after s_req rises with s_rdata=0x12345678 -> s_addr=0x10, s_we=0, c_rdy for 1 cycle with c_rdata=0x12345678, v_rdy never set.
REQ-039 SHALL cover a cache write: c_we=1, c_wdata=0xCAFEF00D -> s_we=1, s_wdata=0xCAFEF00D, c_rdy pulse, c_rdata unchanged.
REQ-040 SHALL cover contention: c_req and v_req held at 1 for 4 transactions after reset -> grant order C,V,C,V, each with exactly one matching rdy.
REQ-041 SHALL cover timeout: TIMEOUT=8, v_req=1, s_done never asserted -> s_req falls after 8 BUSY cycles, v_rdy and err_timeout pulse together, v_rdata=0xFFFFFFFF.
REQ-042 SHALL cover the simultaneous case: s_done in the same cycle the timeout is reached, s_rdata=0xA5A5A5A5 -> normal rdy, rdata=0xA5A5A5A5, err_timeout=0.
REQ-043 SHALL cover reset mid-operation: rst pulsed 1 during BUSY_C -> s_req=0 in the same cycle, no c_rdy, FSM in IDLE, the next contention grants the cache.
